// File: rtl/pattern_match_periph.sv
// rtl/pattern_match_periph.sv - memory-mapped pattern matcher with serial compare FSM
module pattern_match_periph #(
  parameter int PAT_MAX = 8,
  parameter int CNT_W   = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] daddr,
  input  logic [31:0] dwdata,
  input  logic [3:0]  dwe,
  output logic [31:0] drdata
);

  typedef enum logic {IDLE = 1'b0, CMP = 1'b1} state_t;

  localparam logic [3:0] PMAX = 4'(PAT_MAX);

  state_t state, state_nx;

  logic [7:0]       pat  [16];
  logic [7:0]       hist [16];
  logic [3:0]       pat_len, fill, k;
  logic [CNT_W-1:0] match_count;
  logic             match_flag, err;

  logic       cmd_ok, op_load, op_stream, op_clear;
  logic [3:0] fill_inc, pidx;
  logic       byte_eq, last;
  logic       busy, do_load, do_stream, start, step, hit, set_err;
  logic [31:0] status;
  logic       unused_bits;

  assign cmd_ok    = (dwe == 4'b1111);
  assign op_load   = cmd_ok && (dwdata[31:30] == 2'b01);
  assign op_stream = cmd_ok && (dwdata[31:30] == 2'b10);
  assign op_clear  = cmd_ok && (dwdata[31:30] == 2'b11);

  assign fill_inc = (fill == PMAX) ? fill : fill + 4'd1;
  // Newest history byte is compared against the last pattern byte first.
  assign pidx    = pat_len - 4'd1 - k;
  assign byte_eq = (hist[k] == pat[pidx]);
  assign last    = (k == pat_len - 4'd1);

  assign unused_bits = ^{daddr[31:3], daddr[1:0], dwdata[29:8]};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    if (op_clear) begin
      state_nx = IDLE;
    end else begin
      case (state)
        IDLE:    if (start) state_nx = CMP;
        CMP:     if (!byte_eq || last) state_nx = IDLE;
        default: state_nx = IDLE;
      endcase
    end
  end

  always_comb begin
    busy      = (state == CMP);
    do_load   = 1'b0;
    do_stream = 1'b0;
    start     = 1'b0;
    step      = 1'b0;
    hit       = 1'b0;
    set_err   = 1'b0;
    if (!op_clear) begin
      case (state)
        IDLE: begin
          if (op_load) begin
            if (pat_len < PMAX) do_load = 1'b1;
            else                set_err = 1'b1;
          end
          if (op_stream) begin
            do_stream = 1'b1;
            start     = (pat_len != 4'd0) && (fill_inc >= pat_len);
          end
        end
        CMP: begin
          set_err = op_load || op_stream;
          step    = byte_eq && !last;
          hit     = byte_eq && last;
        end
        default: ;
      endcase
    end
  end

  // Byte storage is don't-care after reset/CLEAR, so it carries no reset.
  always_ff @(posedge clk) begin
    if (do_load) pat[pat_len] <= dwdata[7:0];
    if (do_stream) begin
      hist[0] <= dwdata[7:0];
      for (int i = 1; i < 16; i++) hist[i] <= hist[i-1];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pat_len     <= 4'd0;
      fill        <= 4'd0;
      k           <= 4'd0;
      match_count <= '0;
      match_flag  <= 1'b0;
      err         <= 1'b0;
    end else if (op_clear) begin
      pat_len     <= 4'd0;
      fill        <= 4'd0;
      k           <= 4'd0;
      match_count <= '0;
      match_flag  <= 1'b0;
      err         <= 1'b0;
    end else begin
      if (do_load) pat_len <= pat_len + 4'd1;
      if (do_stream) begin
        fill       <= fill_inc;
        match_flag <= 1'b0;
        k          <= 4'd0;
      end
      if (step) k <= k + 4'd1;
      if (hit) begin
        if (match_count != {CNT_W{1'b1}}) match_count <= match_count + CNT_W'(1);
        match_flag <= 1'b1;
      end
      if (set_err) err <= 1'b1;
    end
  end

  always_comb begin
    status            = 32'h0;
    status[31]        = busy;
    status[30]        = err;
    status[29]        = match_flag;
    status[23:20]     = pat_len;
    status[CNT_W-1:0] = match_count;
    drdata            = daddr[2] ? status : 32'h0;
  end

endmodule
